msg_fsm: RTL

MSG_FSM -- requirements
Module: msg_fsm

---
 rtl/msg_pkg.sv | 17 +
 rtl/msg_fsm_if.sv | 26 ++
 rtl/msg_fsm_timeout.sv | 35 +++
 rtl/msg_fsm.sv | 120 ++++++++++++
 4 files changed

// File: rtl/msg_pkg.sv
// Shared definitions for the message sender: FSM state encoding and the
// default terminator value.
package msg_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CHECK,
        S_START,
        S_WAIT_HI,
        S_WAIT_LO,
        S_DONE
    } msg_state_e;

    localparam int MSG_TERM_DEFAULT = 0;

endpackage

// File: rtl/msg_fsm_if.sv
// Bus between the message FSM (master) and its memory/UART environment (slave).
interface msg_fsm_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              restart_i;
    logic [ADDR_W-1:0] base_i;
    logic [DATA_W-1:0] byte_i;
    logic              busy_i;
    logic              start_o;
    logic [ADDR_W-1:0] address_o;
    logic              active_o;
    logic              done_o;
    logic              err_o;
    logic [ADDR_W:0]   count_o;

    modport master (
        input  restart_i, base_i, byte_i, busy_i,
        output start_o, address_o, active_o, done_o, err_o, count_o
    );

    modport slave (
        output restart_i, base_i, byte_i, busy_i,
        input  start_o, address_o, active_o, done_o, err_o, count_o
    );
endinterface

// File: rtl/msg_fsm_timeout.sv
// Busy-acknowledge timeout: counts enabled cycles and flags expiry on the
// BUSY_TO-th waiting cycle.
module msg_fsm_timeout #(
    parameter int BUSY_TO = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int CNT_W = $clog2(BUSY_TO + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expired_o = en_i && (cnt_q == CNT_W'(BUSY_TO - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/msg_fsm.sv
// Message sender: walks memory from base_i, hands each byte to a UART until a
// terminator or the top address. Define MSG_FSM_LOOP_EN to resend endlessly.
module msg_fsm
    import msg_pkg::*;
#(
    parameter int                DATA_W  = 8,
    parameter int                ADDR_W  = 4,
    parameter logic [DATA_W-1:0] TERM    = DATA_W'(MSG_TERM_DEFAULT),
    parameter int                BUSY_TO = 1024
) (
    input  logic     clk_i,
    input  logic     rst_i,
    msg_fsm_if.master bus
);
    localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;
    localparam logic [ADDR_W:0]   COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

    msg_state_e        state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   count_q;
    logic              start_q;
    logic              active_q;
    logic              done_q;
    logic              err_q;
    logic              tmo_expired;

    // CHECK is the only way into START, so clearing there restarts the count on every entry.
    msg_fsm_timeout #(
        .BUSY_TO (BUSY_TO)
    ) u_timeout (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (state_q == S_CHECK),
        .en_i      (state_q == S_START),
        .expired_o (tmo_expired)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            count_q  <= '0;
            start_q  <= 1'b0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.restart_i) begin
                        addr_q   <= bus.base_i;
                        count_q  <= '0;
                        err_q    <= 1'b0;
                        active_q <= 1'b1;
                        state_q  <= S_FETCH;
                    end
                end
                S_FETCH: state_q <= S_CHECK;
                S_CHECK: begin
                    if (bus.byte_i == TERM) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        start_q <= 1'b1;
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    if (bus.busy_i) begin
                        start_q <= 1'b0;
                        state_q <= S_WAIT_LO;
                    end else if (tmo_expired) begin
                        start_q  <= 1'b0;
                        err_q    <= 1'b1;
                        active_q <= 1'b0;
                        state_q  <= S_IDLE;
                    end
                end
                S_WAIT_LO: begin
                    if (!bus.busy_i) begin
                        if (count_q != COUNT_MAX) begin
                            count_q <= count_q + 1'b1;
                        end
                        if (addr_q == ADDR_MAX) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            addr_q  <= addr_q + 1'b1;
                            state_q <= S_FETCH;
                        end
                    end
                end
                S_DONE: begin
`ifdef MSG_FSM_LOOP_EN
                    addr_q  <= bus.base_i;
                    count_q <= '0;
                    state_q <= S_FETCH;
`else
                    active_q <= 1'b0;
                    state_q  <= S_IDLE;
`endif
                end
                // WAIT_HI is never entered: acceptance is taken directly in START.
                default: begin
                    start_q  <= 1'b0;
                    active_q <= 1'b0;
                    state_q  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.start_o   = start_q;
    assign bus.address_o = addr_q;
    assign bus.active_o  = active_q;
    assign bus.done_o    = done_q;
    assign bus.err_o     = err_q;
    assign bus.count_o   = count_q;
endmodule
